// File: rtl/ssm_step_scheduler.sv
// ssm_step_scheduler
//
// Sequences a run of timesteps through the MAC -> bias -> sigmoid ->
// EW-update -> gate pipeline. Each timestep is a burst of D/TILE_SIZE tile
// tokens offered on the MAC input stream. A credit counter bounds the number
// of tiles in flight, and tiles are retired by watching the gate output
// handshake. Between steps the block waits for every tile to retire. This
// barrier keeps EW state reads of step t+1 behind the writes of step t.
//
// Optional feature: define SSM_SCHED_PERF_EN to add three 32-bit performance
// counters (busy cycles, credit stalls, TREADY stalls). They are cleared on
// reset and on command acceptance.
//
// Ports
//   clk, rst          : single rising-edge clock, synchronous active-high reset
//   cmd_valid/ready   : run request handshake; cmd_ready is high only in IDLE
//   cmd_steps         : number of timesteps in the requested run
//   mac_TVALID/TREADY : tile token handshake towards the pipeline s_axis
//   y_TVALID/TREADY   : monitored gate output handshake; each beat retires a tile
//   sof               : high with mac_TVALID on tile 0 of every step
//   tile_idx          : index of the tile currently offered
//   step_idx          : current step
//   inflight          : tiles issued but not yet retired
//   busy              : scheduler is not idle
//   step_done         : one-cycle pulse when a step is fully retired
//   run_done          : one-cycle pulse at the end of a run
//   err_underflow     : sticky; a retire was seen with nothing in flight
//   perf_*            : (SSM_SCHED_PERF_EN only) performance counters
module ssm_step_scheduler #(
  parameter int TILE_SIZE = 4,
  parameter int D         = 256,
  parameter int TILE_W    = $clog2(D / TILE_SIZE),
  parameter int STEP_W    = 16,
  parameter int CREDITS   = 8,
  parameter int CRED_W    = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              mac_TVALID,
  input  logic              mac_TREADY,
  input  logic              y_TVALID,
  input  logic              y_TREADY,
  output logic              sof,
  output logic [TILE_W-1:0] tile_idx,
  output logic [STEP_W-1:0] step_idx,
  output logic [CRED_W-1:0] inflight,
  output logic              busy,
  output logic              step_done,
  output logic              run_done,
  output logic              err_underflow
`ifdef SSM_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_credit_stall,
  output logic [31:0]       perf_tready_stall
`endif
);

  localparam int                TILES     = D / TILE_SIZE;
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES - 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(CREDITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
  logic [STEP_W-1:0]   step_idx_q, step_idx_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [CRED_W-1:0]   inflight_q, inflight_d;
  logic                err_q, err_d;
  logic                zero_hold_q, zero_hold_d;

  logic                issue;
  logic                retire;
  logic                accept;
  logic                last_tile;
  logic                last_step;
  logic                drained;

  // ---------------------------------------------------------------------------
  // Output decode: every output comes from registers only.
  // ---------------------------------------------------------------------------
  always_comb begin
    mac_TVALID = (state_q == ISSUE) && (inflight_q < CRED_MAX);
    sof        = mac_TVALID && (tile_idx_q == '0);
    drained    = (state_q == DRAIN) && (inflight_q == '0);
    step_done  = drained;
    // A zero-step run spends two cycles in FIN. run_done is suppressed on the
    // first one, so it lands two cycles after acceptance. A normal run leaves
    // FIN after one cycle, the cycle after the final step_done.
    run_done   = (state_q == FIN) && !zero_hold_q;
    busy       = (state_q != IDLE);
  end

  assign cmd_ready     = cmd_ready_q;
  assign tile_idx      = tile_idx_q;
  assign step_idx      = step_idx_q;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

  assign issue     = mac_TVALID && mac_TREADY;
  assign retire    = y_TVALID && y_TREADY;
  assign accept    = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign last_tile = (tile_idx_q == TILE_LAST);
  assign last_step = (step_idx_q == (steps_q - STEP_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tile_idx_d  = tile_idx_q;
    step_idx_d  = step_idx_q;
    steps_d     = steps_q;
    zero_hold_d = zero_hold_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          steps_d    = cmd_steps;
          step_idx_d = '0;
          tile_idx_d = '0;
          if (cmd_steps == '0) begin
            state_d     = FIN;
            zero_hold_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          if (last_tile) begin
            tile_idx_d = '0;
            state_d    = DRAIN;
          end else begin
            tile_idx_d = tile_idx_q + TILE_W'(1);
          end
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          step_idx_d = step_idx_q + STEP_W'(1);
          state_d    = last_step ? FIN : ISSUE;
        end
      end
      FIN: begin
        if (zero_hold_q) begin
          zero_hold_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // Credit accounting runs in every state. A retire with nothing in flight
  // flags underflow and the counter saturates at zero.
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q | (retire && (inflight_q == '0));
    if (issue && !retire) begin
      inflight_d = inflight_q + CRED_W'(1);
    end else if (retire && !issue && (inflight_q != '0)) begin
      inflight_d = inflight_q - CRED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      tile_idx_q  <= '0;
      step_idx_q  <= '0;
      steps_q     <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      zero_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      tile_idx_q  <= tile_idx_d;
      step_idx_q  <= step_idx_d;
      steps_q     <= steps_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      zero_hold_q <= zero_hold_d;
    end
  end

`ifdef SSM_SCHED_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_credit_stall_q, perf_credit_stall_d;
  logic [31:0] perf_tready_stall_q, perf_tready_stall_d;

  always_comb begin
    perf_cycles_d       = perf_cycles_q;
    perf_credit_stall_d = perf_credit_stall_q;
    perf_tready_stall_d = perf_tready_stall_q;
    if (accept) begin
      perf_cycles_d       = '0;
      perf_credit_stall_d = '0;
      perf_tready_stall_d = '0;
    end else begin
      if (busy) begin
        perf_cycles_d = perf_cycles_q + 32'd1;
      end
      if ((state_q == ISSUE) && (inflight_q == CRED_MAX)) begin
        perf_credit_stall_d = perf_credit_stall_q + 32'd1;
      end
      if (mac_TVALID && !mac_TREADY) begin
        perf_tready_stall_d = perf_tready_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q       <= '0;
      perf_credit_stall_q <= '0;
      perf_tready_stall_q <= '0;
    end else begin
      perf_cycles_q       <= perf_cycles_d;
      perf_credit_stall_q <= perf_credit_stall_d;
      perf_tready_stall_q <= perf_tready_stall_d;
    end
  end

  assign perf_cycles       = perf_cycles_q;
  assign perf_credit_stall = perf_credit_stall_q;
  assign perf_tready_stall = perf_tready_stall_q;
`endif

endmodule

// File: tb/tb_ssm_step_scheduler.sv
// Self-checking bench for ssm_step_scheduler (default build, no perf counters).
// The expected issue sequence (step, tile, sof) is queued when a command is
// accepted and popped as the DUT issues tiles. A y sink returns each issued
// tile after a configurable delay, and a credit model tracks inflight.
module tb_ssm_step_scheduler;
  localparam int TILE_SIZE = 4;
  localparam int D         = 256;
  localparam int TILES     = D / TILE_SIZE;
  localparam int TILE_W    = $clog2(TILES);
  localparam int STEP_W    = 16;
  localparam int CREDITS   = 8;
  localparam int CRED_W    = $clog2(CREDITS + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              mac_TREADY = 1'b0;
  logic              y_TVALID = 1'b0;
  logic              y_TREADY = 1'b0;
  logic              cmd_ready, mac_TVALID, sof, busy, step_done, run_done, err_underflow;
  logic [TILE_W-1:0] tile_idx;
  logic [STEP_W-1:0] step_idx;
  logic [CRED_W-1:0] inflight;

  ssm_step_scheduler #(
    .TILE_SIZE(TILE_SIZE),
    .D        (D),
    .TILE_W   (TILE_W),
    .STEP_W   (STEP_W),
    .CREDITS  (CREDITS),
    .CRED_W   (CRED_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_steps    (cmd_steps),
    .mac_TVALID   (mac_TVALID),
    .mac_TREADY   (mac_TREADY),
    .y_TVALID     (y_TVALID),
    .y_TREADY     (y_TREADY),
    .sof          (sof),
    .tile_idx     (tile_idx),
    .step_idx     (step_idx),
    .inflight     (inflight),
    .busy         (busy),
    .step_done    (step_done),
    .run_done     (run_done),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int step;
    int tile;
    bit sof;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  int   ret_q[$];
  int   mdl_inflight = 0;
  int   peak = 0;
  bit   exp_err = 1'b0;
  int   n_issue, n_sd, n_rd, acc_cyc, first_v_cyc, last_sd_cyc, rd_cyc;
  bit   cmd_pending = 1'b0;
  int   pend_steps = 0;
  int   ret_delay = 4;
  int   y_block = 0;
  int   probe_rel = -1;
  bit   rand_tready = 1'b0;
  bit   spur = 1'b0;
  bit   abort_arm = 1'b0;
  bit   in_reset = 1'b0;
  bit   prev_wait = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_mac_TVALID"}, mac_TVALID, 0);
    chk({tag, "_sof"}, sof, 0);
    chk({tag, "_tile_idx"}, tile_idx, 0);
    chk({tag, "_step_idx"}, step_idx, 0);
    chk({tag, "_inflight"}, inflight, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_step_done"}, step_done, 0);
    chk({tag, "_run_done"}, run_done, 0);
    chk({tag, "_err_underflow"}, err_underflow, 0);
  endtask

  task automatic clear_run_stats();
    n_issue = 0; n_sd = 0; n_rd = 0; acc_cyc = -1; first_v_cyc = -1;
    last_sd_cyc = -1; rd_cyc = -1; peak = 0;
  endtask

  // One clock: observe outputs at the falling edge, check them against the
  // models, then drive inputs for the next rising edge and update the models.
  task automatic tick();
    bit   iss;
    bit   ret;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (in_reset) begin
      check_reset_vals("mid_reset");
      rst = 1'b0;
      in_reset = 1'b0;
      return;
    end
    if (step_done) begin n_sd++; last_sd_cyc = cyc; end
    if (run_done) begin n_rd++; rd_cyc = cyc; end
    if (mac_TVALID && first_v_cyc < 0) first_v_cyc = cyc;
    chk("inflight", inflight, mdl_inflight);
    chk("err_underflow", err_underflow, exp_err);
    chk("credit_cap", mac_TVALID && (mdl_inflight >= CREDITS), 0);
    chk("sof_gate", sof && !mac_TVALID, 0);
    if (prev_wait) chk("valid_hold", mac_TVALID, 1);
    if (mdl_inflight > peak) peak = mdl_inflight;
    if (probe_rel >= 0 && acc_cyc >= 0 && cyc == acc_cyc + probe_rel) begin
      chk("stall_issues", n_issue, CREDITS);
      chk("stall_valid", mac_TVALID, 0);
    end
    if (abort_arm && mac_TVALID && step_idx == 1 && tile_idx == 30) begin
      rst = 1'b1; in_reset = 1'b1; abort_arm = 1'b0;
      cmd_valid = 1'b0; mac_TREADY = 1'b0; y_TVALID = 1'b0;
      mdl_inflight = 0; exp_err = 1'b0; prev_wait = 1'b0;
      exp_q.delete(); ret_q.delete();
      return;
    end

    cmd_valid  = cmd_pending;
    cmd_steps  = STEP_W'(pend_steps);
    mac_TREADY = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    y_TREADY   = 1'b1;
    y_TVALID   = spur || (ret_q.size() > 0 && ret_q[0] <= cyc && cyc >= y_block);
    spur       = 1'b0;

    iss = mac_TVALID && mac_TREADY;
    ret = y_TVALID && y_TREADY;
    prev_wait = mac_TVALID && !mac_TREADY;

    if (cmd_pending && cmd_ready) begin
      cmd_pending = 1'b0;
      acc_cyc = cyc;
      for (int s = 0; s < pend_steps; s++)
        for (int t = 0; t < TILES; t++)
          exp_q.push_back('{s, t, (t == 0)});
    end
    if (iss) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        chk("extra_issue", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tile_idx", tile_idx, e.tile);
        chk("step_idx", step_idx, e.step);
        chk("sof", sof, e.sof);
        if (e.tile == 0) chk("barrier", n_sd, e.step);
      end
      ret_q.push_back(cyc + ret_delay);
    end
    if (ret) begin
      if (mdl_inflight == 0) exp_err = 1'b1;
      if (ret_q.size() > 0) void'(ret_q.pop_front());
    end
    if (iss && !ret) mdl_inflight++;
    else if (ret && !iss && mdl_inflight > 0) mdl_inflight--;
  endtask

  task automatic run(input int steps, input int delay, input int yblk_rel,
                     input bit rnd, input int probe, input string tag);
    int budget;
    clear_run_stats();
    pend_steps  = steps;
    cmd_pending = 1'b1;
    ret_delay   = delay;
    rand_tready = rnd;
    probe_rel   = probe;
    y_block     = cyc + yblk_rel;
    budget      = 2000 + steps * TILES * (delay + 2) * 2;
    while (n_rd == 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_finished"}, n_rd, 1);
    repeat (3) tick();
    chk({tag, "_issues"}, n_issue, steps * TILES);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
    chk({tag, "_step_done"}, n_sd, steps);
    chk({tag, "_run_done"}, n_rd, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_ready_after"}, cmd_ready, 1);
    if (steps == 0) begin
      chk({tag, "_zero_latency"}, rd_cyc - acc_cyc, 2);
    end else begin
      chk({tag, "_rd_after_sd"}, rd_cyc - last_sd_cyc, 1);
      chk({tag, "_cmd_latency"}, first_v_cyc - acc_cyc, 1);
    end
    probe_rel   = -1;
    rand_tready = 1'b0;
  endtask

  initial begin
    int budget;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    run(1, 4, 0, 1'b0, -1, "t1_single");
    chk("t1_peak", peak, 4);
    run(2, 1, 50, 1'b0, 40, "t2_credit");
    run(3, 10, 0, 1'b0, -1, "t3_barrier");
    run(2, 8, 0, 1'b0, -1, "t4_ceiling");
    chk("t4_peak", peak, CREDITS);
    run(2, 8, 0, 1'b1, -1, "t4_random_ready");
    run(0, 4, 0, 1'b0, -1, "t5_zero");

    spur = 1'b1;
    tick();
    tick();
    chk("t5_spur_err", err_underflow, 1);
    chk("t5_spur_inflight", inflight, 0);

    clear_run_stats();
    pend_steps  = 2;
    cmd_pending = 1'b1;
    ret_delay   = 4;
    y_block     = cyc;
    abort_arm   = 1'b1;
    budget      = 1000;
    while ((abort_arm || in_reset) && budget > 0) begin
      tick();
      budget--;
    end
    chk("t6_abort_reached", abort_arm || in_reset, 0);
    tick();
    chk("t6_ready", cmd_ready, 1);
    chk("t6_err_cleared", err_underflow, 0);
    run(1, 4, 0, 1'b1, -1, "t6_rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
